// File: rtl/aes_serial_host_if.sv
// rtl/aes_serial_host_if.sv - request/response and byte-serial AES bus bundle
interface aes_serial_host_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         in_decrypt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_error;
  logic [7:0]   ser_data_in;
  logic [4:0]   ser_addr;
  logic         ser_wr_en;
  logic         ser_start;
  logic         ser_decrypt;
  logic [7:0]   ser_data_out;
  logic         ser_done;

  modport master (
    input  in_valid, in_data, in_key, in_decrypt, out_ready, ser_data_out, ser_done,
    output in_ready, out_valid, out_data, out_error,
           ser_data_in, ser_addr, ser_wr_en, ser_start, ser_decrypt
  );

  modport slave (
    output in_valid, in_data, in_key, in_decrypt, out_ready, ser_data_out, ser_done,
    input  in_ready, out_valid, out_data, out_error,
           ser_data_in, ser_addr, ser_wr_en, ser_start, ser_decrypt
  );
endinterface

// File: rtl/aes_serial_host.sv
// rtl/aes_serial_host.sv - host initiator running one block through the byte-serial AES interface
module aes_serial_host #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input logic               clk,
  input logic               rst_n,
  aes_serial_host_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  logic [2:0]       r_state;
  logic [4:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [255:0]     r_wr_shift;
  logic [127:0]     r_out_data;
  logic             r_out_error;
  logic             r_decrypt;
  logic             r_rdy_ok;

  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_timeout;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));

  // in_ready is held low while reset is asserted and for the first edge after it
  assign bus.in_ready    = r_rdy_ok && (r_state == S_IDLE) && !bus.ser_done;
  assign bus.out_valid   = (r_state == S_RESP);
  assign bus.out_data    = r_out_data;
  assign bus.out_error   = r_out_error;
  assign bus.ser_wr_en   = (r_state == S_WRITE);
  assign bus.ser_addr    = ((r_state == S_WRITE) || ((r_state == S_READ) && !r_idx[4])) ? r_idx : 5'd0;
  assign bus.ser_data_in = (r_state == S_WRITE) ? r_wr_shift[255:248] : 8'd0;
  assign bus.ser_start   = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_READ);
  assign bus.ser_decrypt = r_decrypt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 5'd0;
      r_cnt       <= '0;
      r_wr_shift  <= 256'd0;
      r_out_data  <= 128'd0;
      r_out_error <= 1'b0;
      r_decrypt   <= 1'b0;
      r_rdy_ok    <= 1'b0;
    end else begin
      r_rdy_ok <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr_shift  <= {bus.in_data, bus.in_key};
            r_decrypt   <= bus.in_decrypt;
            r_idx       <= 5'd0;
            r_out_data  <= 128'd0;
            r_out_error <= 1'b0;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // data bytes then key bytes, most significant byte first
          r_wr_shift <= {r_wr_shift[247:0], 8'h00};
          if (r_idx == 5'd31) begin
            r_idx   <= 5'd0;
            r_state <= S_START;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ser_done) begin
            r_idx   <= 5'd0;
            r_state <= S_READ;
          end else if (w_timeout) begin
            r_out_error <= 1'b1;
            r_out_data  <= 128'd0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_READ: begin
          // the slave registers its output, so byte i arrives one cycle after addr i
          for (int k = 0; k < 16; k++) begin
            if (r_idx == 5'(k + 1)) r_out_data[127-8*k -: 8] <= bus.ser_data_out;
          end
          if (r_idx == 5'd16) begin
            r_idx   <= 5'd0;
            r_state <= S_RELEASE;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        S_RELEASE: begin
          if (!bus.ser_done) r_state <= S_RESP;
        end
        S_RESP: begin
          if (bus.out_ready) begin
            r_decrypt <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_serial_host.sv
// tb/tb_aes_serial_host.sv - directed and randomized bench for aes_serial_host with a byte-serial slave model
module tb_aes_serial_host;
  localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PATTERN = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_serial_host_if bus();

  aes_serial_host #(.TIMEOUT_CYCLES(16), .CNT_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // behaviour of the serial AES engine: known FIPS-197 vectors, otherwise a cheap stand-in
  function automatic logic [127:0] engine(input logic [127:0] d, input logic [127:0] k,
                                          input logic dec, input int md);
    if (md == 1) return PATTERN;
    if (k == FIPS_K && !dec && d == FIPS_PT) return FIPS_CT;
    if (k == FIPS_K &&  dec && d == FIPS_CT) return FIPS_PT;
    return d ^ k ^ {128{dec}};
  endfunction

  // serial slave model: 0 = engine, 1 = fixed pattern, 2 = never done
  int          mode = 0;
  int          done_dly = 3;
  logic [7:0]  mem [32];
  logic [127:0] s_res;
  int          s_cnt;

  function automatic logic [127:0] mem_block(input int base);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], mem[base+i]};
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ser_done     <= 1'b0;
      bus.ser_data_out <= 8'd0;
      s_res            <= '0;
      s_cnt            <= 0;
    end else begin
      if (bus.ser_wr_en) mem[bus.ser_addr] <= bus.ser_data_in;
      bus.ser_data_out <= (bus.ser_addr < 5'd16) ? s_res[127-8*bus.ser_addr -: 8] : 8'd0;
      if (bus.ser_start && !bus.ser_done) begin
        if (s_cnt + 1 >= done_dly && mode != 2) begin
          bus.ser_done <= 1'b1;
          s_res        <= engine(mem_block(0), mem_block(16), bus.ser_decrypt, mode);
          s_cnt        <= 0;
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end else if (!bus.ser_start && bus.ser_done) begin
        if (s_cnt >= 1) begin
          bus.ser_done <= 1'b0;
          s_cnt        <= 0;
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end else if (!bus.ser_start) begin
        s_cnt <= 0;
      end
    end
  end

  // protocol monitor, sampled on the falling edge
  int           wr_total = 0, wr_bad = 0, sd_cyc = 0, st_cyc = 0, dec_bad = 0, rdy_bad = 0;
  int           wr_exp = 0;
  logic         cur_dec = 1'b0;
  logic [255:0] cur_bytes = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      wr_exp = 0;
    end else begin
      if (bus.ser_wr_en) begin
        wr_total++;
        if (bus.ser_addr != wr_exp[4:0] || bus.ser_start ||
            bus.ser_data_in != cur_bytes[255-8*wr_exp -: 8]) wr_bad++;
        wr_exp = (wr_exp + 1) % 32;
      end
      if (bus.ser_start) st_cyc++;
      if (bus.ser_start && bus.ser_done) sd_cyc++;
      if ((bus.ser_wr_en || bus.ser_start) && bus.ser_decrypt != cur_dec) dec_bad++;
      if ((bus.ser_wr_en || bus.ser_start) && bus.in_ready) rdy_bad++;
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic dec, input string tag);
    int n = 0;
    cur_dec   = dec;
    cur_bytes = {d, k};
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, " in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_key = k; bus.in_decrypt = dec;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_data = ~d; bus.in_key = ~k; bus.in_decrypt = ~dec;
  endtask

  task automatic run_op(input logic [127:0] d, input logic [127:0] k, input logic dec,
                        input int md, input int dly, input int bp,
                        input logic [127:0] exp_data, input logic exp_err,
                        input int exp_sd, input int exp_st, input string tag);
    int n = 0, bp_bad = 0;
    int w0, wb0, sd0, st0, db0, rb0;
    logic [127:0] held;
    mode = md; done_dly = dly;
    w0 = wr_total; wb0 = wr_bad; sd0 = sd_cyc; st0 = st_cyc; db0 = dec_bad; rb0 = rdy_bad;
    send(d, k, dec, tag);
    @(negedge clk);
    while (!bus.out_valid && n < 300) begin @(negedge clk); n++; end
    chk({tag, " out_valid"}, bus.out_valid, 1);
    held = bus.out_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== held || bus.in_ready) bp_bad++;
    end
    if (bp > 0) chk({tag, " backpressure"}, bp_bad, 0);
    chk({tag, " out_data"}, bus.out_data, exp_data);
    chk({tag, " out_error"}, bus.out_error, exp_err);
    chk({tag, " ser_start in resp"}, bus.ser_start, 0);
    chk({tag, " write count"}, wr_total - w0, 32);
    chk({tag, " write order"}, wr_bad - wb0, 0);
    chk({tag, " start&done cycles"}, sd_cyc - sd0, exp_sd);
    chk({tag, " start cycles"}, st_cyc - st0, exp_st);
    chk({tag, " decrypt stable"}, dec_bad - db0, 0);
    chk({tag, " busy in_ready"}, rdy_bad - rb0, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " out_valid drop"}, bus.out_valid, 0);
    chk({tag, " in_ready back"}, bus.in_ready, 1);
  endtask

  initial begin
    logic [127:0] d, k;
    logic dec;
    int dly, n;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_key = '0; bus.in_decrypt = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ctl", {bus.in_ready, bus.out_valid, bus.out_error, bus.ser_wr_en, bus.ser_start,
                      bus.ser_decrypt, bus.ser_addr, bus.ser_data_in}, 0);
    chk("reset out_data", bus.out_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle in_ready", bus.in_ready, 1);

    run_op(FIPS_PT, FIPS_K, 1'b0, 0, 3, 0, FIPS_CT, 1'b0, 18, 21, "fips_enc");
    run_op(FIPS_CT, FIPS_K, 1'b1, 0, 5, 20, FIPS_PT, 1'b0, 18, 23, "fips_dec_bp");
    run_op(FIPS_PT, FIPS_K, 1'b0, 1, 1, 0, PATTERN, 1'b0, 18, 19, "pattern");
    run_op(FIPS_PT, FIPS_K, 1'b0, 2, 1, 2, 128'd0, 1'b1, 0, 17, "timeout");

    mode = 0; done_dly = 2;
    send(FIPS_PT, FIPS_K, 1'b1, "rst_mid");
    n = 0;
    @(negedge clk);
    while (!(bus.ser_wr_en && bus.ser_addr == 5'd10) && n < 50) begin @(negedge clk); n++; end
    chk("rst_mid at addr10", {bus.ser_wr_en, bus.ser_addr}, {1'b1, 5'd10});
    rst_n = 1'b0;
    #1;
    chk("rst_mid ctl", {bus.in_ready, bus.out_valid, bus.out_error, bus.ser_wr_en, bus.ser_start,
                        bus.ser_decrypt, bus.ser_addr, bus.ser_data_in}, 0);
    chk("rst_mid out_data", bus.out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(FIPS_PT, FIPS_K, 1'b0, 0, 2, 0, FIPS_CT, 1'b0, 18, 20, "after_rst");

    for (int i = 0; i < 4; i++) begin
      d   = {$urandom, $urandom, $urandom, $urandom};
      k   = {$urandom, $urandom, $urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      dly = $urandom_range(1, 10);
      run_op(d, k, dec, 0, dly, $urandom_range(0, 3), d ^ k ^ {128{dec}}, 1'b0,
             18, dly + 18, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_serial_host.md
Name: aes_serial_host

Overview:
Host-side initiator for the byte-wide AES serial interface (8-bit data, 5-bit address, wr_en/start/decrypt/done). It accepts a 128-bit block, a 128-bit key and a direction over a valid/ready port, then runs the full serial transaction: 32 byte writes, start, wait for done, 16 pipelined byte reads, start release. It returns the 128-bit result over a valid/ready port. It sits between the on-chip master and the pin-limited AES serial interface.

Parameters:
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT_DONE before the operation is aborted with an error
CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_data  in  128  plaintext/ciphertext block
in_key  in  128  key
in_decrypt  in  1  1 = decrypt, 0 = encrypt
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  128  result block
out_error  out  1  qualifies out_data; 1 = timeout
ser_data_in  out  8  byte to the serial interface
ser_addr  out  5  byte address: 0-15 data, 16-31 key
ser_wr_en  out  1  byte write strobe
ser_start  out  1  level start, held for the whole operation
ser_decrypt  out  1  direction, held stable from WRITE through RELEASE
ser_data_out  in  8  registered read byte; 1-cycle latency from ser_addr
ser_done  in  1  serial interface in complete state

Behaviour:
- Reset (async, rst_n=0) sets all outputs to 0 and the state to IDLE. Reset is honoured mid-operation; the serial slave must be reset together with this block.
- Byte order: addr k (0-15) carries in_data[127-8k -: 8]. Addr 16+k carries in_key[127-8k -: 8]. Read addr k returns result byte k into out_data[127-8k -: 8].
- IDLE:
  - in_ready=1 only in IDLE and only while ser_done=0.
  - On handshake, latch in_data, in_key and in_decrypt; set ser_decrypt; go to WRITE.
- WRITE, exactly 32 cycles:
  - ser_wr_en=1, ser_addr=0..31, one per cycle consecutively; ser_data_in per the byte order.
  - After addr 31, drop ser_wr_en and go to START.
- START, 1 cycle:
  - ser_start=1; clear the timeout counter; go to WAIT_DONE.
  - ser_start stays 1 until RELEASE.
- WAIT_DONE:
  - Increment the timeout counter each cycle.
  - When ser_done=1 is sampled, go to READ with ser_addr=0.
  - When the counter reaches TIMEOUT_CYCLES with no done: set out_error=1, out_data=0, drop ser_start, go to RESP.
- READ, 17 cycles, pipelined:
  - In read cycle i (i=0..15), drive ser_addr=i.
  - At the edge ending read cycle i+1, capture ser_data_out into byte i.
  - The last cycle only captures byte 15. Then go to RELEASE.
- RELEASE:
  - ser_start=0, ser_wr_en=0. Stay until ser_done is sampled 0, then go to RESP with out_error=0.
- RESP:
  - out_valid=1; out_data and out_error are stable.
  - On out_ready, go to IDLE. out_valid drops on the next cycle.
  - in_ready stays 0 until back in IDLE, so there is no back-to-back overlap.
- ser_wr_en is never 1 outside WRITE. ser_start is never 1 during WRITE. ser_addr is 0 when idle.
- Input-to-output latency in cycles: 32 (WRITE) + 1 (START) + wait + 17 (READ) + ≥1 (RELEASE) + 1.
- A new in_valid during busy states is ignored, because in_ready=0.

Test Plan:
- FIPS-197 encrypt: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, decrypt=0 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_error=0; 32 consecutive writes at addr 0..31; ser_start high from START until RELEASE.
- FIPS-197 decrypt: same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, decrypt=1 -> out_data 00112233445566778899aabbccddeeff; ser_decrypt constant for the whole operation.
- Back-pressure: hold out_ready=0 for 20 cycles -> out_valid and out_data stable, in_ready=0; release -> one transfer, then in_ready=1.
- Timeout: bench slave never asserts done, TIMEOUT_CYCLES=16 -> out_error=1, out_data=0 after 16 WAIT_DONE cycles; ser_start=0.
- Read pipeline: slave model returns byte k = 8'hA0+k with 1-cycle latency -> out_data a0a1a2...af; exactly 17 READ cycles.
- Reset mid-WRITE at addr 10 -> all outputs 0 immediately; the next request restarts cleanly from addr 0 and produces the correct result.
